// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with a
// start/done handshake and one operation in flight at a time.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle wide
// multiplier and go straight from accept to DONE; divide is unaffected.

module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;    // {accumulator, multiplier} shift register
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;      // dividend shifts out as quotient shifts in
  logic [XLEN-1:0]     dvsr_q, dvsr_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                in_div, a_signed, b_signed, sign_a, sign_b;
  logic                in_neg, div_zero, div_ovf, in_special, in_fast;
  logic [XLEN-1:0]     mag_a, mag_b, special_res;
  logic [2*XLEN-1:0]   fast_prod;
  logic [XLEN-1:0]     fast_res;

  logic [XLEN:0]       mul_sum;
  logic [XLEN+1:0]     div_shift, div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   mul_full;
  logic [XLEN-1:0]     div_val;

  // Decode the incoming request: operand signedness, magnitudes, negate flag, special cases
  always_comb begin
    in_div   = funct3[2];
    a_signed = in_div ? ~funct3[0] : ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10));
    b_signed = in_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    sign_a   = a_signed & op_a[XLEN-1];
    sign_b   = b_signed & op_b[XLEN-1];
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;
    // Remainder takes the dividend's sign; everything else the XOR of both signs
    in_neg   = (in_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero = in_div && (op_b == '0);
    div_ovf  = in_div && !funct3[0] && (op_a == MinInt) && (op_b == '1);
    in_special = div_zero || div_ovf;
    if (div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else begin
      special_res = funct3[1] ? '0 : MinInt;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle full-width product, resolved entirely at accept
  always_comb begin
    fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
              : (in_neg ? -fast_prod : fast_prod) >> XLEN;
    in_fast   = ~funct3[2];
  end
`else
  // Multiplies take the iterative path
  always_comb begin
    fast_prod = '0;
    fast_res  = '0;
    in_fast   = 1'b0;
  end
`endif

  // One iteration of shift-add multiply and restoring divide, plus final fix-up values
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = div_shift - {2'b00, dvsr_q};
    div_ge    = ~div_diff[XLEN+1];
    mul_full  = neg_q ? -prod_q : prod_q;
    div_val   = op_q[1] ? rem_q[XLEN-1:0] : quo_q;
  end

  // Next-state logic for the FSM, datapath and registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          op_d    = funct3;
          neg_d   = in_neg;
          cnt_d   = '0;
          mcand_d = mag_a;
          prod_d  = in_fast ? fast_prod : {{XLEN{1'b0}}, mag_b};
          rem_d   = '0;
          quo_d   = mag_a;
          dvsr_d  = mag_b;
          if (in_special) begin
            state_d  = StDone;
            result_d = special_res;
          end else if (in_fast) begin
            state_d  = StDone;
            result_d = fast_res;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        if (op_q[2]) begin
          rem_d = div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], div_ge};
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StDone;
        if (op_q[2]) begin
          result_d = neg_q ? -div_val : div_val;
        end else if (op_q[1:0] == 2'b00) begin
          result_d = mul_full[XLEN-1:0];
        end else begin
          result_d = mul_full[2*XLEN-1:XLEN];
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StCalc) || (state_d == StFix);
    done_d = (state_d == StDone);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of RV32M vectors, random ops against
// a 64-bit reference model, and hand-written busy-start, back-to-back and reset sequences.

module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 34;
`endif
  localparam int Limit = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } sb_t;

  sb_t exp_q[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f[2]) return MulLat;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drive a request (start held high) and record what it must produce
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    sb_t e;
    e.res = exp;
    e.lat = lat;
    exp_q.push_back(e);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
  endtask

  // Called #1 after the accept edge; waits for done, compares against the scoreboard.
  // chain: issue the given op in the DONE cycle. ign_at: pulse a bogus start in that cycle.
  task automatic wait_done(input string name, input bit chain, input logic [2:0] cf,
                           input logic [31:0] ca, input logic [31:0] cb,
                           input logic [31:0] ce, input int cl, input int ign_at);
    int  n;
    bit  both;
    sb_t e;
    n = 1;
    both = 1'b0;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    chk({name, "_busy_c1"}, {31'h0, busy}, {31'h0, exp_q[0].lat > 1});
    while (!done && n < Limit) begin
      if (busy && done) both = 1'b1;
      if (n == ign_at) begin
        funct3 = 3'b101;
        op_a   = 32'd5;
        op_b   = 32'd0;
        start  = 1'b1;
      end else if (n == ign_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    e = exp_q.pop_front();
    chk({name, "_done"}, {31'h0, done}, 32'h1);
    chk({name, "_lat"}, 32'(n), 32'(e.lat));
    chk({name, "_res"}, result, e.res);
    chk({name, "_excl"}, {31'h0, both | busy}, 32'h0);
    if (chain) issue(cf, ca, cb, ce, cl);
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(f, a, b, exp, lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(name, 1'b0, 3'b000, '0, '0, '0, 0, -10);
  endtask

  vec_t vecs[0:18];

  initial begin
    bit saw_done;
    int n;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs[0]  = '{"mul_7_m3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat};
    vecs[1]  = '{"mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat};
    vecs[2]  = '{"mulhu_ones",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat};
    vecs[3]  = '{"mulhsu_ones",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat};
    vecs[4]  = '{"div_m20_6",     3'b100, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD, 34};
    vecs[5]  = '{"rem_m20_6",     3'b110, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE, 34};
    vecs[6]  = '{"divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14,        34};
    vecs[7]  = '{"remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         34};
    vecs[8]  = '{"divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"rem_5_0",       3'b110, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{"div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{"div_7_m2",      3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vecs[13] = '{"rem_7_m2",      3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         34};
    vecs[14] = '{"divu_big_10",   3'b101, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 34};
    vecs[15] = '{"remu_big_10",   3'b111, 32'hFFFF_FFFF, 32'd10,        32'd5,         34};
    vecs[16] = '{"mulhu_min_2",   3'b011, 32'h8000_0000, 32'd2,         32'd1,         MulLat};
    vecs[17] = '{"mulh_m1_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         MulLat};
    vecs[18] = '{"mul_ffff_sq",   3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, MulLat};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Random ops against the reference model, with some divide-by-zero thrown in
    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 5 == 0) ? 32'h0 : $urandom;
      run_op("rand", rf, ra, rb, ref_res(rf, ra, rb), ref_lat(rf, ra, rb));
    end

    // Start pulsed in cycle 10 of a busy DIV must be ignored
    issue(3'b100, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 34);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", 1'b0, 3'b000, '0, '0, '0, 0, 10);
    @(posedge clk);
    #1;
    chk("busy_start_no_extra_done", {31'h0, done}, 32'h0);

    // Back-to-back: second op held in the DONE cycle of the first
    issue(3'b101, 32'd100, 32'd7, 32'd14, 34);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("b2b_first", 1'b1, 3'b111, 32'd100, 32'd7, 32'd2, 34, -10);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("b2b_second", 1'b0, 3'b000, '0, '0, '0, 0, -10);

    // Reset asserted in cycle 15 of a DIV
    issue(3'b100, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 34);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (n < 15) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_result", result, 32'h0);
    void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", {31'h0, saw_done}, 32'h0);
    run_op("remu_9_4", 3'b111, 32'd9, 32'd4, 32'd1, 34);

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
